an_serial_decode_argmax: RTL and testbench
==========================================

// Module: an_serial_decode_argmax
// PURPOSE
// - Output stage after layer2 of the AN-coded TCB network (A=59).
// - Takes the NUM_CLASS codewords of the last layer and decodes them one at a time with a shared constant divider.
// - Checks each codeword residue (AN code: a valid codeword is a multiple of A) and flags non-zero residues.
// - Returns the argmax class over error-free classes.
// - Replaces the parallel per-class decoder array plus comparator with one time-shared datapath.
// PARAMETERS
// - A          59  AN-code multiplier; constant divisor.
// - CW_W       29  codeword width, signed two's complement.
// - MSG_W      24  decoded message width, signed.
// - NUM_CLASS  10  number of codewords per inference.
// - REM_W       6  remainder width, $clog2(A).
// PORTS
// - clk         in   1                clock, rising edge.
// - rst         in   1                synchronous, active-high reset.
// - valid       in   1                start pulse; layer_in is sampled in IDLE.
// - layer_in    in   CW_W*NUM_CLASS   codeword k at [CW_W*k +: CW_W].
// - predict     out  32               winning class index; 32'hFFFF_FFFF if no class is error-free.
// - ready       out  1                one-cycle done pulse; predict and error_* are valid from this cycle.
// - error_mask  out  NUM_CLASS        bit k = codeword k had a non-zero residue.
// - error_flag  out  1                OR-reduction of error_mask.
// BEHAVIOUR
// - Reset: all outputs 0, FSM to IDLE, divider cleared. A reset mid-operation aborts the inference; no ready pulse follows.
// - FSM states: IDLE -> DIV -> CMP -> (DIV for next class | DONE) -> IDLE.
// - IDLE
//   - valid=1 at cycle T: register layer_in, idx=0, best_valid=0, clear internal mask.
//   - Go to DIV at T+1.
// - DIV
//   - Load |codeword[idx]| into the divider, which does restoring division by A, one quotient bit per cycle, for CW_W cycles.
//   - Magnitude is CW_W bits unsigned, so -2^(CW_W-1) is legal.
// - CMP (1 cycle)
//   - If remainder != 0: set mask[idx]; class excluded from argmax.
//   - Else: msg = sign-restored quotient, sign-extended to MSG_W.
//   - Replace best when !best_valid or msg > best_msg (signed). Equal values keep the lower index.
//   - If idx == NUM_CLASS-1, go to DONE; else idx++ and go to DIV.
// - DONE (1 cycle)
//   - ready=1 for exactly one cycle.
//   - predict = best_idx, or all-ones if !best_valid. error_mask and error_flag update in the same cycle.
//   - Outputs then hold until the next DONE or reset; ready returns to 0.
// - Latency
//   - CMP of class k occurs at T + (CW_W+1)*(k+1).
//   - ready rises at T + NUM_CLASS*(CW_W+1) + 1, which is T+301 for the defaults.
// - valid while not IDLE: ignored, no queuing. valid in the DONE cycle: ignored. valid held high: retriggers in IDLE the cycle after DONE.
// - Valid message range: |msg| <= floor((2^(CW_W-1)-1)/A) = 4549753.
// STRUCTURE
// - Shared package an_code_pkg: A, CW_W, MSG_W, REM_W, NUM_CLASS, PREDICT_NONE = 32'hFFFF_FFFF, FSM state encoding.
// - Sub-module an_const_divider
//   - Ports: start, dividend[CW_W], busy, done, quotient[CW_W], remainder[REM_W]. Iterative, CW_W cycles.
//   - Top holds the FSM, codeword register, index counter, best_msg/best_idx/best_valid registers and mask.
// TESTING
// - All clean, msg[k]=100*k (codeword 5900*k), valid at T -> ready only at T+301, predict=9, error_mask=0, error_flag=0.
// - Negatives and tie, msg=-5 everywhere except msg[3]=msg[7]=1000 -> predict=3.
// - Single error, codeword[9]=59*900+1, others msg[k]=100*k -> error_mask=10'h200, error_flag=1, predict=8.
// - All error, codeword[k]=59*k+1 -> error_mask=10'h3FF, error_flag=1, predict=32'hFFFF_FFFF.
// - Range edges:
//   - msg[2]=4549753 with msg[5]=-4549753, others 0 -> predict=2, no errors.
//   - codeword[0]=-2^28 (residue !=0) -> error_mask bit0=1.
// - Control: valid pulses at T+50 are ignored (exactly one ready at T+301). rst at T+150 -> outputs 0 and no ready. New valid at T' -> ready at T'+301 with correct result.

Source files
------------

// File: rtl/an_code_pkg.sv
// Shared constants and FSM encoding for the AN-coded (A=59) output stage.
package an_code_pkg;

  localparam int A         = 59;
  localparam int CW_W      = 29;
  localparam int MSG_W     = 24;
  localparam int NUM_CLASS = 10;
  localparam int REM_W     = $clog2(A);
  localparam int IDX_W     = $clog2(NUM_CLASS);

  localparam logic [31:0] PREDICT_NONE = 32'hFFFF_FFFF;

  typedef enum logic [1:0] {
    S_IDLE,
    S_DIV,
    S_CMP,
    S_DONE
  } state_t;

endpackage

// File: rtl/an_const_divider.sv
// Iterative restoring divider by the constant A: one quotient bit per cycle, CW_W cycles.
module an_const_divider
  import an_code_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [CW_W-1:0]  dividend,
  output logic             busy,
  output logic             done,
  output logic [CW_W-1:0]  quotient,
  output logic [REM_W-1:0] remainder
);

  localparam int CNT_W = $clog2(CW_W);

  logic [CW_W-1:0]  q_p0;
  logic [REM_W-1:0] rem_p0;
  logic [CNT_W-1:0] cnt_p0;
  logic             busy_p0;

  logic [CW_W-1:0]  src;
  logic [REM_W-1:0] rem_in;
  logic [REM_W:0]   step_res;

  // Returns {quotient bit, new remainder} for one restoring step.
  function automatic logic [REM_W:0] div_step(input logic [REM_W-1:0] rem,
                                              input logic bit_in);
    logic [REM_W:0] trial;
    logic [REM_W:0] diff;
    trial = {rem, bit_in};
    diff  = trial - (REM_W+1)'(A);
    if (trial >= (REM_W+1)'(A)) div_step = {1'b1, diff[REM_W-1:0]};
    else                        div_step = {1'b0, trial[REM_W-1:0]};
  endfunction

  // The start cycle already performs the first step straight from the dividend.
  always_comb begin
    src      = start ? dividend : q_p0;
    rem_in   = start ? '0 : rem_p0;
    step_res = div_step(rem_in, src[CW_W-1]);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      busy_p0 <= 1'b0;
      cnt_p0  <= '0;
      q_p0    <= '0;
      rem_p0  <= '0;
    end else begin
      if (start) begin
        busy_p0 <= 1'b1;
        cnt_p0  <= CNT_W'(CW_W-1);
      end else if (busy_p0) begin
        cnt_p0 <= cnt_p0 - 1'b1;
        if (cnt_p0 == CNT_W'(1)) busy_p0 <= 1'b0;
      end
      if (start || busy_p0) begin
        q_p0   <= {src[CW_W-2:0], step_res[REM_W]};
        rem_p0 <= step_res[REM_W-1:0];
      end
    end
  end

  // done marks the final step; quotient/remainder are valid from the next cycle.
  assign busy      = busy_p0;
  assign done      = busy_p0 && (cnt_p0 == CNT_W'(1));
  assign quotient  = q_p0;
  assign remainder = rem_p0;

endmodule

// File: rtl/an_serial_decode_argmax.sv
// Time-shared AN-code decoder and argmax over the NUM_CLASS codewords of the last layer.
module an_serial_decode_argmax
  import an_code_pkg::*;
(
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      valid,
  input  logic [CW_W*NUM_CLASS-1:0] layer_in,
  output logic [31:0]               predict,
  output logic                      ready,
  output logic [NUM_CLASS-1:0]      error_mask,
  output logic                      error_flag
);

  state_t                    state_p0, state_nx;
  logic [CW_W*NUM_CLASS-1:0] cw_p0;
  logic [IDX_W-1:0]          idx_p0;
  logic [IDX_W-1:0]          best_idx_p0;
  logic signed [MSG_W-1:0]   best_msg_p0;
  logic                      best_vld_p0;
  logic [NUM_CLASS-1:0]      mask_p0;

  logic                      div_start, div_busy, div_done;
  logic [CW_W-1:0]           div_quot;
  logic [REM_W-1:0]          div_rem;

  logic signed [CW_W-1:0]    cur_cw;
  logic                      cur_neg;
  logic [CW_W-1:0]           cur_mag;
  logic signed [MSG_W-1:0]   cmp_msg;
  logic                      cmp_err, take, last_cls;
  logic                      nb_vld;
  logic [IDX_W-1:0]          nb_idx;
  logic [NUM_CLASS-1:0]      nb_mask;
  logic                      unused_quot_hi;

  function automatic logic signed [MSG_W-1:0] sign_restore(input logic [MSG_W-1:0] q,
                                                           input logic neg);
    sign_restore = neg ? $signed(~q + 1'b1) : $signed(q);
  endfunction

  // Valid codewords keep |msg| well inside MSG_W, so the upper quotient bits are never needed.
  assign unused_quot_hi = ^div_quot[CW_W-1:MSG_W];

  assign cur_cw    = $signed(cw_p0[idx_p0*CW_W +: CW_W]);
  assign cur_neg   = cur_cw[CW_W-1];
  assign cur_mag   = cur_neg ? (~cur_cw + 1'b1) : cur_cw;
  assign div_start = (state_p0 == S_DIV) && !div_busy;

  an_const_divider u_div (
    .clk       (clk),
    .rst       (rst),
    .start     (div_start),
    .dividend  (cur_mag),
    .busy      (div_busy),
    .done      (div_done),
    .quotient  (div_quot),
    .remainder (div_rem)
  );

  // Compare stage: decoded message against the running best; ties keep the lower index.
  always_comb begin
    cmp_msg  = sign_restore(div_quot[MSG_W-1:0], cur_neg);
    cmp_err  = (div_rem != '0);
    take     = !cmp_err && (!best_vld_p0 || (cmp_msg > best_msg_p0));
    last_cls = (idx_p0 == IDX_W'(NUM_CLASS-1));
    nb_vld   = best_vld_p0 || take;
    nb_idx   = take ? idx_p0 : best_idx_p0;
    nb_mask  = mask_p0 | (NUM_CLASS'(cmp_err) << idx_p0);
  end

  always_comb begin
    state_nx = state_p0;
    case (state_p0)
      S_IDLE:  if (valid) state_nx = S_DIV;
      S_DIV:   if (div_done) state_nx = S_CMP;
      S_CMP:   state_nx = last_cls ? S_DONE : S_DIV;
      S_DONE:  state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_p0    <= S_IDLE;
      idx_p0      <= '0;
      best_vld_p0 <= 1'b0;
      mask_p0     <= '0;
      ready       <= 1'b0;
      predict     <= '0;
      error_mask  <= '0;
      error_flag  <= 1'b0;
    end else begin
      state_p0 <= state_nx;
      ready    <= (state_p0 == S_CMP) && last_cls;
      if ((state_p0 == S_IDLE) && valid) begin
        idx_p0      <= '0;
        best_vld_p0 <= 1'b0;
        mask_p0     <= '0;
      end
      if (state_p0 == S_CMP) begin
        best_vld_p0 <= nb_vld;
        mask_p0     <= nb_mask;
        if (last_cls) begin
          predict    <= nb_vld ? 32'(nb_idx) : PREDICT_NONE;
          error_mask <= nb_mask;
          error_flag <= |nb_mask;
        end else begin
          idx_p0 <= idx_p0 + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if ((state_p0 == S_IDLE) && valid) cw_p0 <= layer_in;
    if ((state_p0 == S_CMP) && take) begin
      best_msg_p0 <= cmp_msg;
      best_idx_p0 <= idx_p0;
    end
  end

endmodule

// File: tb/tb_an_serial_decode_argmax.sv
// Scoreboard bench: reference decode/argmax model feeds a queue, a monitor checks each ready pulse.
module tb_an_serial_decode_argmax;
  import an_code_pkg::*;

  localparam int  LAT   = NUM_CLASS*(CW_W+1)+1;
  localparam longint MAXM = 4549753;

  logic                      clk = 1'b0;
  logic                      rst;
  logic                      valid;
  logic [CW_W*NUM_CLASS-1:0] layer_in;
  logic [31:0]               predict;
  logic                      ready;
  logic [NUM_CLASS-1:0]      error_mask;
  logic                      error_flag;

  always #5 clk = ~clk;

  an_serial_decode_argmax dut (
    .clk        (clk),
    .rst        (rst),
    .valid      (valid),
    .layer_in   (layer_in),
    .predict    (predict),
    .ready      (ready),
    .error_mask (error_mask),
    .error_flag (error_flag)
  );

  typedef struct {
    longint               due;
    logic [31:0]          pred;
    logic [NUM_CLASS-1:0] mask;
  } exp_t;

  exp_t   sb[$];
  exp_t   mon_e;
  int     n_chk  = 0;
  int     n_fail = 0;
  longint cyc    = 0;
  longint cw_arr[NUM_CLASS];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input longint act, input longint exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference: decode every clean codeword, take the maximum, report its first occurrence.
  function automatic exp_t model();
    exp_t   e;
    longint msg[NUM_CLASS];
    bit     clean[NUM_CLASS];
    longint mx;
    bit     any;
    e.mask = '0;
    e.pred = PREDICT_NONE;
    e.due  = 0;
    any    = 0;
    mx     = 0;
    for (int k = 0; k < NUM_CLASS; k++) begin
      longint mag;
      mag      = (cw_arr[k] < 0) ? -cw_arr[k] : cw_arr[k];
      clean[k] = ((mag % A) == 0);
      msg[k]   = cw_arr[k] / A;
      if (!clean[k]) e.mask[k] = 1'b1;
      else if (!any || msg[k] > mx) begin
        mx  = msg[k];
        any = 1;
      end
    end
    if (any) begin
      for (int k = NUM_CLASS-1; k >= 0; k--)
        if (clean[k] && msg[k] == mx) e.pred = 32'(k);
    end
    return e;
  endfunction

  task automatic issue();
    exp_t e;
    e = model();
    for (int k = 0; k < NUM_CLASS; k++) layer_in[CW_W*k +: CW_W] = cw_arr[k][CW_W-1:0];
    valid = 1'b1;
    e.due = cyc + LAT;
    sb.push_back(e);
    tick();
    valid = 1'b0;
  endtask

  task automatic wait_done();
    for (int i = 0; i < LAT + 20 && sb.size() > 0; i++) tick();
    if (sb.size() > 0) begin
      n_chk++;
      n_fail++;
      $display("FAIL timeout: %0d results outstanding, required 0", sb.size());
      sb.delete();
    end
    tick();
  endtask

  always @(posedge clk) begin
    #1;
    if (!rst) begin
      if (ready) begin
        if (sb.size() == 0) begin
          n_chk++;
          n_fail++;
          $display("FAIL unexpected_ready: got ready=1 at cycle %0d, required no pulse", cyc);
        end else begin
          mon_e = sb.pop_front();
          chk("ready_cycle", cyc, mon_e.due);
          chk("predict", predict, mon_e.pred);
          chk("error_mask", error_mask, mon_e.mask);
          chk("error_flag", error_flag, |mon_e.mask);
        end
      end else if (sb.size() > 0 && cyc > sb[0].due) begin
        n_chk++;
        n_fail++;
        $display("FAIL missing_ready: no pulse by cycle %0d, required at %0d", cyc, sb[0].due);
        void'(sb.pop_front());
      end
    end
  end

  initial begin
    rst      = 1'b1;
    valid    = 1'b0;
    layer_in = '0;
    repeat (3) tick();
    chk("reset_predict", predict, 0);
    chk("reset_mask", error_mask, 0);
    chk("reset_flag", error_flag, 0);
    chk("reset_ready", ready, 0);
    rst = 1'b0;
    tick();

    for (int k = 0; k < NUM_CLASS; k++) cw_arr[k] = 5900 * k;
    issue();
    wait_done();

    for (int k = 0; k < NUM_CLASS; k++) cw_arr[k] = -5 * A;
    cw_arr[3] = 1000 * A;
    cw_arr[7] = 1000 * A;
    issue();
    wait_done();

    for (int k = 0; k < NUM_CLASS; k++) cw_arr[k] = 5900 * k;
    cw_arr[9] = A * 900 + 1;
    issue();
    wait_done();

    for (int k = 0; k < NUM_CLASS; k++) cw_arr[k] = A * k + 1;
    issue();
    wait_done();

    for (int k = 0; k < NUM_CLASS; k++) cw_arr[k] = 0;
    cw_arr[2] = A * MAXM;
    cw_arr[5] = -A * MAXM;
    issue();
    wait_done();

    for (int k = 0; k < NUM_CLASS; k++) cw_arr[k] = 0;
    cw_arr[0] = -268435456;
    issue();
    wait_done();

    // valid pulse with different data in the middle of an inference must be ignored
    for (int k = 0; k < NUM_CLASS; k++) cw_arr[k] = 5900 * k;
    issue();
    repeat (49) tick();
    layer_in = '1;
    valid    = 1'b1;
    tick();
    valid    = 1'b0;
    wait_done();

    // reset in the middle aborts without a ready pulse
    for (int k = 0; k < NUM_CLASS; k++) cw_arr[k] = -7 * A;
    cw_arr[4] = 3 * A + 2;
    issue();
    repeat (149) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    sb.delete();
    chk("midrst_predict", predict, 0);
    chk("midrst_mask", error_mask, 0);
    chk("midrst_flag", error_flag, 0);
    chk("midrst_ready", ready, 0);
    repeat (LAT + 10) tick();
    issue();
    wait_done();

    for (int t = 0; t < 8; t++) begin
      for (int k = 0; k < NUM_CLASS; k++) begin
        longint m;
        case ($urandom_range(0, 3))
          0: begin
            m = longint'($urandom_range(0, 2*MAXM)) - MAXM;
            cw_arr[k] = A * m;
          end
          1: begin
            m = longint'($urandom_range(0, 8000000)) - 4000000;
            cw_arr[k] = A * m + longint'($urandom_range(1, A-1));
          end
          2: cw_arr[k] = A * (longint'($urandom_range(0, 6)) - 3);
          default: cw_arr[k] = (k > 0) ? cw_arr[0] : A * 17;
        endcase
      end
      issue();
      wait_done();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
